// File: rtl/bin2bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int BCD_DIGIT_W = 4;

  // Decimal digits needed for the full range of a bin_w-bit unsigned value:
  // ceil(bin_w * log10(2)), with log10(2) scaled by 1e5.
  function automatic int min_digits(input int bin_w);
    longint acc;
    acc = 0;
    for (int i = 0; i < bin_w; i++) begin
      acc += longint'(30103);
    end
    return int'((acc + longint'(99999)) / longint'(100000));
  endfunction

endpackage

// File: rtl/bin2bcd_seq_digit_adj.sv
// Double-dabble digit correction: a digit of 5 or more gets +3, wrapping within 4 bits.
module bcd_digit_adj
  import bin2bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic [BCD_DIGIT_W-1:0] adj_digit
);

  assign adj_digit = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Bit-serial binary-to-BCD converter, BIN_W cycles accept-to-result; result held under back-pressure.
// Optional leading-zero blanking output when BIN2BCD_LZ_BLANK_EN is defined.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3,
  parameter int CNT_W  = $clog2(BIN_W + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [BIN_W-1:0]            bin_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
  output logic                        ovf
`ifdef BIN2BCD_LZ_BLANK_EN
  ,
  output logic [DIGITS-1:0]           blank_n
`endif
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  // With enough digits for the full input range nothing can spill out of the top digit.
  localparam bit CAN_OVF = (DIGITS < min_digits(BIN_W));
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_W);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t             state;
  state_t             state_nxt;
  logic [BIN_W-1:0]   shift_reg;
  logic [CNT_W-1:0]   cnt;
  logic [BCD_W-1:0]   digits;
  logic [BCD_W-1:0]   adj;
  logic [BCD_W-1:0]   digits_nxt;
  logic               accept;
  logic               last_shift;

  for (genvar k = 0; k < DIGITS; k++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit     (digits[BCD_DIGIT_W*k +: BCD_DIGIT_W]),
      .adj_digit (adj[BCD_DIGIT_W*k +: BCD_DIGIT_W])
    );
  end

  assign digits_nxt = {adj[BCD_W-2:0], shift_reg[BIN_W-1]};
  assign in_ready   = (state == IDLE);
  assign accept     = in_valid && in_ready;
  assign last_shift = (state == SHIFT) && (cnt == CNT_ONE);
  assign bcd_out    = digits;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid)        state_nxt = SHIFT;
      SHIFT:   if (cnt == CNT_ONE)  state_nxt = DONE;
      DONE:    if (out_ready)       state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      out_valid <= (state_nxt == DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
      digits    <= '0;
      ovf       <= 1'b0;
      cnt       <= '0;
    end else if (accept) begin
      shift_reg <= bin_in;
      digits    <= '0;
      ovf       <= 1'b0;
      cnt       <= CNT_LOAD;
    end else if (state == SHIFT) begin
      shift_reg <= shift_reg << 1;
      digits    <= digits_nxt;
      ovf       <= ovf | (CAN_OVF & adj[BCD_W-1]);
      cnt       <= cnt - CNT_ONE;
    end
  end

`ifdef BIN2BCD_LZ_BLANK_EN
  logic [DIGITS-1:0] blank_nxt;
  logic              upper_nz;

  // Scan from the top digit down; a digit stays lit once any digit at or above it is nonzero.
  always_comb begin
    upper_nz  = 1'b0;
    blank_nxt = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      upper_nz     = upper_nz | (digits_nxt[BCD_DIGIT_W*k +: BCD_DIGIT_W] != '0);
      blank_nxt[k] = upper_nz || (k == 0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank_n <= '0;
    end else if (last_shift) begin
      blank_n <= blank_nxt;
    end
  end
`else
  logic unused_last_shift;
  assign unused_last_shift = last_shift;
`endif

endmodule
